// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: control-state encoding and packed-BCD display format.
// The display driver imports the same package for the decimal-point position.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;
  localparam logic [15:0] BCD_FULL      = 16'h9999;
  localparam int unsigned DP_DIGIT      = 2;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous debounced button, followed by a
// registered rising-edge detector that emits one single-cycle pulse per press.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch core: 100 Hz prescaler, run/pause/clear control, SS.hh packed-BCD count
// and a lap freeze that holds the displayed value while the live count keeps going.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000000,
  parameter bit          WRAP     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [15:0] bcd,
  output logic        running,
  output logic        lap_active,
  output logic        at_max
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic start_p, clear_p, lap_p;

  btn_sync_edge u_sync_start (.clk(clk), .rst(rst), .btn_in(btn_start_stop), .pulse(start_p));
  btn_sync_edge u_sync_clear (.clk(clk), .rst(rst), .btn_in(btn_clear),      .pulse(clear_p));
  btn_sync_edge u_sync_lap   (.clk(clk), .rst(rst), .btn_in(btn_lap),        .pulse(lap_p));

  sw_state_e        state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      lap_q, lap_d;
  logic             lap_active_q, lap_active_d;

  logic        tick;
  logic        live_max;
  logic        clear_ok;
  logic        carry;
  logic [15:0] count_inc;

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    tick         = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    live_max     = (count_q == BCD_FULL);
    // Clear is only honoured when stopped; in RUN it is dropped even alongside start.
    clear_ok     = clear_p && (state_q != ST_RUN);

    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == BCD_DIGIT_MAX) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        pre_d = '0;
        if (start_p && !clear_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (start_p)                          state_d = ST_PAUSE;
        else if (tick && live_max && !WRAP)   state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear_p)      state_d = ST_IDLE;
        else if (start_p) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick) begin
      if (!live_max)  count_d = count_inc;
      else if (WRAP)  count_d = 16'h0000;
    end

    if (lap_p) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else if (state_q == ST_RUN) begin
        lap_d        = count_q;
        lap_active_d = 1'b1;
      end
    end

    if (clear_ok) begin
      pre_d        = '0;
      count_d      = 16'h0000;
      lap_d        = 16'h0000;
      lap_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      count_q      <= 16'h0000;
      lap_q        <= 16'h0000;
      lap_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
    end
  end

  assign bcd        = lap_active_q ? lap_q : count_q;
  assign running    = (state_q == ST_RUN);
  assign lap_active = lap_active_q;
  assign at_max     = (count_q == BCD_FULL);

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: a wrapping and a saturating instance share stimulus and
// are checked every cycle against an integer-count model plus hand-computed literal values.
module tb_stopwatch_bcd_counter;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic clk, rst, btn_start_stop, btn_clear, btn_lap;
  logic [15:0] bcd_w, bcd_s;
  logic run_w, lap_w, max_w, run_s, lap_s, max_s;

  int tests = 0;
  int fails = 0;

  stopwatch_bcd_counter #(.TICK_DIV(TD), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
    .btn_lap(btn_lap), .bcd(bcd_w), .running(run_w), .lap_active(lap_w), .at_max(max_w));

  stopwatch_bcd_counter #(.TICK_DIV(TD), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
    .btn_lap(btn_lap), .bcd(bcd_s), .running(run_s), .lap_active(lap_s), .at_max(max_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: index 0 wraps, index 1 saturates. Count held as a plain integer 0..9999.
  int m_state[2], m_pre[2], m_cnt[2], m_lap[2];
  bit m_act[2];
  bit [3:0] hs, hc, hl;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    bit ps, pc, pl, tick, clr;
    int st, nst, npre, ncnt, nlap;
    bit nact;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        m_state[m] = M_IDLE; m_pre[m] = 0; m_cnt[m] = 0; m_lap[m] = 0; m_act[m] = 0;
      end
      hs = '0; hc = '0; hl = '0;
    end else begin
      // A level first sampled at edge k acts on the state at edge k+3.
      ps = hs[2] & ~hs[3];
      pc = hc[2] & ~hc[3];
      pl = hl[2] & ~hl[3];
      for (int m = 0; m < 2; m++) begin
        st   = m_state[m];
        tick = (st == M_RUN) && (m_pre[m] == TD - 1);
        clr  = pc && (st != M_RUN);
        nst = st; npre = m_pre[m]; ncnt = m_cnt[m]; nlap = m_lap[m]; nact = m_act[m];
        if (st == M_IDLE) begin
          npre = 0;
          if (ps && !pc) nst = M_RUN;
        end else if (st == M_RUN) begin
          npre = tick ? 0 : m_pre[m] + 1;
          if (ps) nst = M_PAUSE;
          else if (tick && m_cnt[m] == 9999 && m == 1) nst = M_PAUSE;
        end else begin
          if (pc) nst = M_IDLE;
          else if (ps) nst = M_RUN;
        end
        if (tick) ncnt = (m_cnt[m] == 9999) ? ((m == 0) ? 0 : 9999) : m_cnt[m] + 1;
        if (pl) begin
          if (m_act[m]) nact = 0;
          else if (st == M_RUN) begin nlap = m_cnt[m]; nact = 1; end
        end
        if (clr) begin npre = 0; ncnt = 0; nlap = 0; nact = 0; end
        m_state[m] = nst; m_pre[m] = npre; m_cnt[m] = ncnt; m_lap[m] = nlap; m_act[m] = nact;
      end
      hs = {hs[2:0], btn_start_stop};
      hc = {hc[2:0], btn_clear};
      hl = {hl[2:0], btn_lap};
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int m, input string tag, input logic [15:0] b,
                     input logic r, input logic la, input logic mx);
    logic [15:0] eb;
    eb = m_act[m] ? to_bcd(m_lap[m]) : to_bcd(m_cnt[m]);
    chk({tag, "_bcd"},     b,      eb);
    chk({tag, "_running"}, 16'(r),  16'(m_state[m] == M_RUN));
    chk({tag, "_lap"},     16'(la), 16'(m_act[m]));
    chk({tag, "_at_max"},  16'(mx), 16'(m_cnt[m] == 9999));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp(0, "model_wrap", bcd_w, run_w, lap_w, max_w);
      cmp(1, "model_sat",  bcd_s, run_s, lap_s, max_s);
    end
  end

  task automatic press(input bit s, input bit c, input bit l);
    btn_start_stop = s; btn_clear = c; btn_lap = l;
    @(negedge clk);
    btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
  endtask

  task automatic wait_cnt(input int v, input int budget);
    int n;
    n = 0;
    while (m_cnt[0] != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_cnt[0] != v) chk("wait_cnt_timeout", 16'(m_cnt[0]), 16'(v));
  endtask

  initial begin
    rst = 1'b1; btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_bcd", bcd_w, 16'h0000);
    chk("reset_running", 16'(run_w), 16'd0);
    chk("reset_lap", 16'(lap_w), 16'd0);
    chk("reset_at_max", 16'(max_w), 16'd0);
    rst = 1'b0;

    press(1, 0, 0);
    repeat (2) @(negedge clk);
    chk("start_not_yet", 16'(run_w), 16'd0);
    @(negedge clk);
    chk("start_latency", 16'(run_w), 16'd1);
    repeat (40) @(negedge clk);
    chk("count_40cyc", bcd_w, 16'h0010);
    repeat (360) @(negedge clk);
    chk("count_400cyc", bcd_w, 16'h0100);

    press(1, 0, 0); repeat (3) @(negedge clk);
    press(0, 1, 0); repeat (3) @(negedge clk);
    chk("stop_clear_bcd", bcd_w, 16'h0000);
    chk("stop_clear_running", 16'(run_w), 16'd0);

    press(1, 0, 0); repeat (3) @(negedge clk);
    wait_cnt(11, 200);
    repeat (2) @(negedge clk);
    press(1, 0, 0); repeat (3) @(negedge clk);
    chk("pause_bcd", bcd_w, 16'h0012);
    chk("pause_running", 16'(run_w), 16'd0);
    repeat (100) @(negedge clk);
    chk("pause_hold_bcd", bcd_w, 16'h0012);
    press(1, 0, 0); repeat (4) @(negedge clk);
    chk("resume_pre_tick", bcd_w, 16'h0012);
    chk("resume_running", 16'(run_w), 16'd1);
    @(negedge clk);
    chk("resume_partial_period", bcd_w, 16'h0013);

    wait_cnt(25, 200);
    press(0, 1, 0); repeat (17) @(negedge clk);
    chk("clear_ignored_bcd", bcd_w, 16'h0029);
    chk("clear_ignored_run", 16'(run_w), 16'd1);

    press(0, 0, 1); repeat (3) @(negedge clk);
    chk("lap_freeze_bcd", bcd_w, 16'h0030);
    chk("lap_active_set", 16'(lap_w), 16'd1);
    repeat (40) @(negedge clk);
    chk("lap_frozen_bcd", bcd_w, 16'h0030);
    chk("lap_live_at_max", 16'(max_w), 16'd0);
    repeat (56) @(negedge clk);
    press(0, 0, 1); repeat (3) @(negedge clk);
    chk("unlap_bcd", bcd_w, 16'h0055);
    chk("unlap_active", 16'(lap_w), 16'd0);

    press(1, 0, 0); repeat (3) @(negedge clk);
    chk("pause2_running", 16'(run_w), 16'd0);
    press(1, 1, 0); repeat (3) @(negedge clk);
    chk("simul_clear_bcd", bcd_w, 16'h0000);
    repeat (10) @(negedge clk);
    chk("simul_clear_idle", 16'(run_w), 16'd0);
    chk("simul_clear_bcd_hold", bcd_w, 16'h0000);

    press(1, 0, 0); repeat (3) @(negedge clk);
    press(0, 0, 1); repeat (3) @(negedge clk);
    chk("pre_rst_lap", 16'(lap_w), 16'd1);
    wait_cnt(345, 2000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_bcd", bcd_w, 16'h0000);
    chk("midrun_rst_running", 16'(run_w), 16'd0);
    chk("midrun_rst_lap", 16'(lap_w), 16'd0);

    btn_start_stop = 1'b1;
    repeat (1000) @(negedge clk);
    chk("held_one_toggle", 16'(run_w), 16'd1);
    btn_start_stop = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_release", 16'(run_w), 16'd1);

    wait_cnt(999, 5000);
    chk("pre_carry_bcd", bcd_w, 16'h0999);
    repeat (4) @(negedge clk);
    chk("carry_chain_bcd", bcd_w, 16'h1000);

    wait_cnt(9999, 40000);
    chk("full_bcd_w", bcd_w, 16'h9999);
    chk("full_at_max_w", 16'(max_w), 16'd1);
    repeat (4) @(negedge clk);
    chk("wrap_bcd", bcd_w, 16'h0000);
    chk("wrap_running", 16'(run_w), 16'd1);
    chk("wrap_at_max", 16'(max_w), 16'd0);
    chk("sat_bcd", bcd_s, 16'h9999);
    chk("sat_running", 16'(run_s), 16'd0);
    chk("sat_at_max", 16'(max_s), 16'd1);

    press(1, 0, 0); repeat (3) @(negedge clk);
    chk("sat_restart_running", 16'(run_s), 16'd1);
    repeat (8) @(negedge clk);
    chk("sat_restart_bcd", bcd_s, 16'h9999);
    chk("sat_repause", 16'(run_s), 16'd0);
    press(0, 1, 0); repeat (3) @(negedge clk);
    chk("sat_clear_bcd", bcd_s, 16'h0000);
    chk("sat_clear_at_max", 16'(max_s), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
